cella_cmd_decoder: RTL and testbench
====================================

Name: cella_cmd_decoder

Overview:
- Array-side receiver of the CELLA command bus (op_code/addr/data_bank/data_in) that the host/stimulus drives at one command per clk.
- Decodes each command into one-hot bank/row selects and write/MAC/CAM strobes for the macro.
- Tracks which weight rows have been loaded and frames consecutive MACs into bursts.
- Keeps saturating activity counters.
- No backpressure: one command must be accepted every cycle.

Parameters:
- NBANK, 16, number of banks; addr[8:5] selects the bank.
- NROW, 4, rows per bank; addr[4:3] selects the row.
- DW, 16, data width of data_bank, data_in and the data outputs.
- CW, 16, width of each activity counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_code  in  2  command: 00 MAC, 01 WRITE, 10 CAM, 11 NOP.
- addr  in  9  {bank[3:0], row[1:0], col[2:0]}; col is reserved and ignored.
- data_bank  in  DW  weight for WRITE, key for CAM, pass-through for MAC.
- data_in  in  DW  activation vector for MAC/CAM.
- bank_sel  out  NBANK  one-hot bank select; all 1s for CAM.
- row_sel  out  NROW  one-hot row select.
- wr_en  out  1  weight write strobe.
- mac_en  out  1  MAC strobe.
- cam_en  out  1  CAM search strobe.
- mac_start  out  1  first MAC of a burst.
- mac_last  out  1  last MAC of a burst.
- wdata  out  DW  registered data_bank.
- act  out  DW  registered data_in.
- loaded  out  NBANK*NROW  scoreboard; bit index = bank*NROW+row.
- cmd_err  out  1  MAC/CAM issued to an unloaded row (one-cycle pulse).
- wr_cnt, mac_cnt, cam_cnt  out  CW each  saturating command counters.

Behaviour:
- Pipeline: S1 registers the raw command every cycle; S2 registers the decoded outputs. Latency is 2 clk from bus sample to strobe.
  - S2 uses S1 plus the command currently on the bus as one-command lookahead.
- Reset, asynchronous on rst_n low:
  - All outputs 0, S1 op forced to NOP, loaded = 0, counters = 0, FSM = IDLE.
  - Reset mid-burst drops the burst with no mac_last.
  - The first command sampled after rst_n rises is decoded normally.
- WRITE:
  - Outputs: wr_en=1, bank_sel=onehot(bank), row_sel=onehot(row), wdata=data_bank.
  - loaded[bank*NROW+row] is set in the same cycle wr_en asserts.
  - Rewriting a row is legal; it raises no error.
- MAC:
  - Outputs: mac_en=1, bank_sel/row_sel from addr, act=data_in, wdata=data_bank.
  - cmd_err=1 with mac_en if that row's loaded bit is 0; the strobe is still issued.
- CAM:
  - Outputs: cam_en=1, bank_sel=all 1s, row_sel=onehot(row), wdata=key, act=data_in.
  - cmd_err=1 if any bank's loaded bit for that row is 0.
- NOP: all strobes 0; bank_sel/row_sel/wdata/act hold their previous values.
- FSM states: IDLE, WRITE, MAC_BURST, CAM. The state reflects the op held in S2.
  - Any -> MAC_BURST on MAC; MAC_BURST -> MAC_BURST while the next op is MAC to the same {bank,row}.
  - Any -> WRITE / CAM / IDLE on WRITE / CAM / NOP.
- Burst framing:
  - mac_start=1 when the S2 MAC's predecessor was not a MAC to the same {bank,row}.
  - mac_last=1 when the lookahead command is not a MAC to the same {bank,row}.
  - A single isolated MAC has both mac_start and mac_last = 1.
- Simultaneous write-then-MAC: a WRITE immediately followed by a MAC to the same row is not an error. The scoreboard update is bypassed into the next cycle's check.
- Counters: each increments once per strobe and saturates at 2^CW-1 (no wrap).
- Strobe exclusivity: the strobes are mutually exclusive by construction; at most one is 1 in any cycle.

Decomposition:
- Package cella_pkg:
  - op_code localparams OP_MAC=2'b00, OP_WR=2'b01, OP_CAM=2'b10, OP_NOP=2'b11.
  - Address field slice constants (BANK_MSB=8, BANK_LSB=5, ROW_MSB=4, ROW_LSB=3).
  - FSM state encoding.
- One sub-module: cella_scoreboard. It holds the loaded bitmap, set-on-write with bypass, and the MAC/CAM row check.
- Counters and burst framing stay in the top.

Test Plan:
- Reset hold, then NOP stream -> all outputs 0, loaded=0, counters 0, no strobes.
- Write all 16 banks x 4 rows with data_bank=bank+row, one per cycle:
  - wr_en high 64 consecutive cycles, starting 2 clk after the first command.
  - wdata sequence 0x0000, 0x0001, ..., 0x0012.
  - loaded=all 1s, wr_cnt=64.
- After the loads, MAC bank0/row0 (data_in=0xFFFF), MAC row0 (0xF0FF), MAC row1 (0xFFFF), MAC row0 (data_bank=0x0010), then CAM row0 (key 0x000F):
  - start/last per MAC = (1,0), (0,1), (1,1), (1,1).
  - Then cam_en with bank_sel=0xFFFF, row_sel=0001; mac_cnt=4, cam_cnt=1, cmd_err never asserted.
- From reset, MAC to bank3/row2 -> mac_en=1 and cmd_err=1.
  - Then WRITE to bank3/row2 followed immediately by MAC to bank3/row2 -> second MAC has cmd_err=0.
- CAM row1 after loading row1 in banks 0-14 only -> cmd_err=1 with cam_en.
- Assert rst_n low mid-MAC-burst -> all outputs 0 asynchronously, no mac_last, loaded cleared.
- Force counters near max with CW=4 and issue 20 writes -> wr_cnt sticks at 15.

Source files
------------

// File: rtl/cella_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cella_pkg
//  Description : Shared constants for the CELLA command decoder: op codes,
//                address field positions and FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cella_pkg;

  // Command bus op codes
  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CAM = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Address layout {bank[3:0], row[1:0], col[2:0]}
  localparam int BANK_MSB = 8;
  localparam int BANK_LSB = 5;
  localparam int ROW_MSB  = 4;
  localparam int ROW_LSB  = 3;
  localparam int BANK_W   = BANK_MSB - BANK_LSB + 1;
  localparam int ROW_W    = ROW_MSB - ROW_LSB + 1;

  // FSM state encoding: the state mirrors the op held in the output stage
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_CAM   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cella_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : cella_scoreboard
//  Description : Loaded-row bitmap. Sets a bit on every WRITE and flags MAC
//                (single row) or CAM (row across all banks) commands that
//                touch rows never written.
//  Revision    : 1.0  initial release
// ============================================================================
module cella_scoreboard
  import cella_pkg::*;
#(
  parameter int NBANK = 16,
  parameter int NROW  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr,
  input  logic                    i_chk_mac,
  input  logic                    i_chk_cam,
  input  logic [BANK_W-1:0]       i_bank,
  input  logic [ROW_W-1:0]        i_row,
  output logic [NBANK*NROW-1:0]   o_loaded,
  output logic                    o_err
);

  // Bit index bank*NROW+row; NROW is a power of two so this is a concatenation
  logic [BANK_W+ROW_W-1:0] w_idx;
  logic [NBANK-1:0]        w_row_bits;
  logic [NBANK*NROW-1:0]   r_loaded;

  assign w_idx = {i_bank, i_row};

  // Gather the selected row's loaded bit from every bank for CAM searches
  generate
    for (genvar b = 0; b < NBANK; b++) begin : g_cam_row
      localparam logic [BANK_W-1:0] c_bank = BANK_W'(b);
      assign w_row_bits[b] = r_loaded[{c_bank, i_row}];
    end
  endgenerate

  // Set-on-write bitmap. The set lands on the same edge the decoder raises
  // wr_en, so a MAC right behind the WRITE already sees the bit one cycle on
  // and a back-to-back write-then-MAC never reports an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loaded <= '0;
    end else if (i_wr) begin
      r_loaded[w_idx] <= 1'b1;
    end
  end

  // Row check: MAC needs its own row, CAM needs that row in every bank
  always_comb begin
    o_err = (i_chk_mac & ~r_loaded[w_idx]) | (i_chk_cam & ~(&w_row_bits));
  end

  assign o_loaded = r_loaded;

endmodule
`default_nettype wire

// File: rtl/cella_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cella_cmd_decoder
//  Description : Two-stage receiver for the CELLA command bus. Stage 1 holds
//                the raw command, stage 2 drives one-hot selects, strobes,
//                MAC burst framing, row-load errors and activity counters.
//  Revision    : 1.0  initial release
// ============================================================================
module cella_cmd_decoder #(
  parameter int NBANK = 16,
  parameter int NROW  = 4,
  parameter int DW    = 16,
  parameter int CW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            op_code,
  input  logic [8:0]            addr,
  input  logic [DW-1:0]         data_bank,
  input  logic [DW-1:0]         data_in,
  output logic [NBANK-1:0]      bank_sel,
  output logic [NROW-1:0]       row_sel,
  output logic                  wr_en,
  output logic                  mac_en,
  output logic                  cam_en,
  output logic                  mac_start,
  output logic                  mac_last,
  output logic [DW-1:0]         wdata,
  output logic [DW-1:0]         act,
  output logic [NBANK*NROW-1:0] loaded,
  output logic                  cmd_err,
  output logic [CW-1:0]         wr_cnt,
  output logic [CW-1:0]         mac_cnt,
  output logic [CW-1:0]         cam_cnt
);

  import cella_pkg::*;

  // Stage 1: raw command
  logic [1:0]        r_s1_op;
  logic [BANK_W-1:0] r_s1_bank;
  logic [ROW_W-1:0]  r_s1_row;
  logic [DW-1:0]     r_s1_db;
  logic [DW-1:0]     r_s1_din;

  // Stage 2: decoded outputs and burst context
  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [NBANK-1:0]       r_bank_sel;
  logic [NROW-1:0]        r_row_sel;
  logic [DW-1:0]          r_wdata;
  logic [DW-1:0]          r_act;
  logic                   r_err;
  logic                   r_start;
  logic                   r_last;
  logic [BANK_W+ROW_W-1:0] r_s2_br;
  logic [CW-1:0]          r_wr_cnt;
  logic [CW-1:0]          r_mac_cnt;
  logic [CW-1:0]          r_cam_cnt;

  logic [BANK_W+ROW_W-1:0] w_s1_br;
  logic [BANK_W+ROW_W-1:0] w_bus_br;
  logic                    w_s1_mac;
  logic                    w_sb_err;
  logic                    w_unused_col;

  assign w_s1_br      = {r_s1_bank, r_s1_row};
  assign w_bus_br     = {addr[BANK_MSB:BANK_LSB], addr[ROW_MSB:ROW_LSB]};
  assign w_s1_mac     = (r_s1_op == OP_MAC);
  assign w_unused_col = ^addr[2:0];

  // Stage 1 captures the bus every cycle; reset parks it on NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_op   <= OP_NOP;
      r_s1_bank <= '0;
      r_s1_row  <= '0;
      r_s1_db   <= '0;
      r_s1_din  <= '0;
    end else begin
      r_s1_op   <= op_code;
      r_s1_bank <= addr[BANK_MSB:BANK_LSB];
      r_s1_row  <= addr[ROW_MSB:ROW_LSB];
      r_s1_db   <= data_bank;
      r_s1_din  <= data_in;
    end
  end

  cella_scoreboard #(
    .NBANK (NBANK),
    .NROW  (NROW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (r_s1_op == OP_WR),
    .i_chk_mac (w_s1_mac),
    .i_chk_cam (r_s1_op == OP_CAM),
    .i_bank    (r_s1_bank),
    .i_row     (r_s1_row),
    .o_loaded  (loaded),
    .o_err     (w_sb_err)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: follows the op moving from stage 1 into stage 2
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_s1_op)
      OP_MAC:  w_state_next = ST_MAC;
      OP_WR:   w_state_next = ST_WRITE;
      OP_CAM:  w_state_next = ST_CAM;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: strobes are decoded from one state, so they are exclusive
  always_comb begin
    wr_en  = (r_state == ST_WRITE);
    mac_en = (r_state == ST_MAC);
    cam_en = (r_state == ST_CAM);
  end

  // Stage 2 datapath: selects/data update per op and hold across NOPs;
  // burst edges compare against the previous stage-2 op and the bus lookahead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel <= '0;
      r_row_sel  <= '0;
      r_wdata    <= '0;
      r_act      <= '0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
      r_last     <= 1'b0;
      r_s2_br    <= '0;
    end else begin
      case (r_s1_op)
        OP_WR: begin
          r_bank_sel <= NBANK'(1) << r_s1_bank;
          r_row_sel  <= NROW'(1) << r_s1_row;
          r_wdata    <= r_s1_db;
        end
        OP_MAC: begin
          r_bank_sel <= NBANK'(1) << r_s1_bank;
          r_row_sel  <= NROW'(1) << r_s1_row;
          r_wdata    <= r_s1_db;
          r_act      <= r_s1_din;
        end
        OP_CAM: begin
          r_bank_sel <= '1;
          r_row_sel  <= NROW'(1) << r_s1_row;
          r_wdata    <= r_s1_db;
          r_act      <= r_s1_din;
        end
        OP_NOP: begin
        end
        default: begin
        end
      endcase
      r_err   <= w_sb_err;
      r_start <= w_s1_mac & ~((r_state == ST_MAC) && (r_s2_br == w_s1_br));
      r_last  <= w_s1_mac & ~((op_code == OP_MAC) && (w_bus_br == w_s1_br));
      r_s2_br <= w_s1_br;
    end
  end

  // Saturating activity counters, stepped on the edge that raises each strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_mac_cnt <= '0;
      r_cam_cnt <= '0;
    end else begin
      if ((w_state_next == ST_WRITE) && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + CW'(1);
      end
      if ((w_state_next == ST_MAC) && (r_mac_cnt != '1)) begin
        r_mac_cnt <= r_mac_cnt + CW'(1);
      end
      if ((w_state_next == ST_CAM) && (r_cam_cnt != '1)) begin
        r_cam_cnt <= r_cam_cnt + CW'(1);
      end
    end
  end

  assign bank_sel  = r_bank_sel;
  assign row_sel   = r_row_sel;
  assign wdata     = r_wdata;
  assign act       = r_act;
  assign cmd_err   = r_err;
  assign mac_start = r_start;
  assign mac_last  = r_last;
  assign wr_cnt    = r_wr_cnt;
  assign mac_cnt   = r_mac_cnt;
  assign cam_cnt   = r_cam_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cella_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cella_cmd_decoder
//  Description : Directed, table-driven bench for cella_cmd_decoder. Each
//                command vector carries hand-computed outputs that appear two
//                clocks after the command is driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cella_cmd_decoder;

  import cella_pkg::*;

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [15:0] db;
    logic [15:0] din;
    bit          chk;
    logic        wr, mac, cam, st, ls, err;
    logic [15:0] bsel;
    logic [3:0]  rsel;
    logic [15:0] wdata;
    logic [15:0] act;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  op_code;
  logic [8:0]  addr;
  logic [15:0] data_bank, data_in;

  logic [15:0] bank_sel;
  logic [3:0]  row_sel;
  logic        wr_en, mac_en, cam_en, mac_start, mac_last, cmd_err;
  logic [15:0] wdata, act;
  logic [63:0] loaded;
  logic [15:0] wr_cnt, mac_cnt, cam_cnt;

  logic [15:0] s_bank_sel;
  logic [3:0]  s_row_sel;
  logic        s_wr_en, s_mac_en, s_cam_en, s_mac_start, s_mac_last, s_cmd_err;
  logic [15:0] s_wdata, s_act;
  logic [63:0] s_loaded;
  logic [3:0]  s_wr_cnt, s_mac_cnt, s_cam_cnt;

  int n_err = 0;
  int n_chk = 0;
  int vid   = 0;

  vec_t h0, h1;
  bit   h0_v = 1'b0, h1_v = 1'b0;
  int   h0_id, h1_id;

  vec_t tbl_mac[7];
  vec_t tbl_err[4];
  vec_t nop_z;
  vec_t nop_x;

  always #5 clk = ~clk;

  cella_cmd_decoder #(.NBANK(16), .NROW(4), .DW(16), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .addr(addr),
    .data_bank(data_bank), .data_in(data_in),
    .bank_sel(bank_sel), .row_sel(row_sel), .wr_en(wr_en), .mac_en(mac_en),
    .cam_en(cam_en), .mac_start(mac_start), .mac_last(mac_last),
    .wdata(wdata), .act(act), .loaded(loaded), .cmd_err(cmd_err),
    .wr_cnt(wr_cnt), .mac_cnt(mac_cnt), .cam_cnt(cam_cnt)
  );

  cella_cmd_decoder #(.NBANK(16), .NROW(4), .DW(16), .CW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .addr(addr),
    .data_bank(data_bank), .data_in(data_in),
    .bank_sel(s_bank_sel), .row_sel(s_row_sel), .wr_en(s_wr_en), .mac_en(s_mac_en),
    .cam_en(s_cam_en), .mac_start(s_mac_start), .mac_last(s_mac_last),
    .wdata(s_wdata), .act(s_act), .loaded(s_loaded), .cmd_err(s_cmd_err),
    .wr_cnt(s_wr_cnt), .mac_cnt(s_mac_cnt), .cam_cnt(s_cam_cnt)
  );

  function automatic vec_t mk(input logic [1:0] op, input logic [8:0] a,
                              input logic [15:0] db, input logic [15:0] din,
                              input bit chk, input logic wr, input logic mac,
                              input logic cam, input logic st, input logic ls,
                              input logic err, input logic [15:0] bsel,
                              input logic [3:0] rsel, input logic [15:0] wd,
                              input logic [15:0] ac);
    vec_t v;
    v.op = op; v.addr = a; v.db = db; v.din = din; v.chk = chk;
    v.wr = wr; v.mac = mac; v.cam = cam; v.st = st; v.ls = ls; v.err = err;
    v.bsel = bsel; v.rsel = rsel; v.wdata = wd; v.act = ac;
    return v;
  endfunction

  task automatic chk(input string name, input int id,
                     input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h want %h", name, id, got, want);
    end
  endtask

  task automatic cmp_vec(input vec_t e, input int id);
    if (e.chk) begin
      chk("wr_en",     id, 64'(wr_en),     64'(e.wr));
      chk("mac_en",    id, 64'(mac_en),    64'(e.mac));
      chk("cam_en",    id, 64'(cam_en),    64'(e.cam));
      chk("mac_start", id, 64'(mac_start), 64'(e.st));
      chk("mac_last",  id, 64'(mac_last),  64'(e.ls));
      chk("cmd_err",   id, 64'(cmd_err),   64'(e.err));
      chk("bank_sel",  id, 64'(bank_sel),  64'(e.bsel));
      chk("row_sel",   id, 64'(row_sel),   64'(e.rsel));
      chk("wdata",     id, 64'(wdata),     64'(e.wdata));
      chk("act",       id, 64'(act),       64'(e.act));
      chk("strobe_excl", id, 64'((32'(wr_en) + 32'(mac_en) + 32'(cam_en)) <= 32'd1), 64'd1);
    end
  endtask

  // One bus cycle: compare the vector driven two cycles ago, then drive v
  task automatic step(input vec_t v);
    @(negedge clk);
    if (h1_v) cmp_vec(h1, h1_id);
    h1 = h0; h1_v = h0_v; h1_id = h0_id;
    h0 = v;  h0_v = 1'b1; h0_id = vid;
    vid++;
    op_code = v.op; addr = v.addr; data_bank = v.db; data_in = v.din;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strobes"}, vid, 64'({wr_en, mac_en, cam_en, mac_start, mac_last, cmd_err}), 64'd0);
    chk({tag, "_sel"},     vid, 64'({bank_sel, row_sel}), 64'd0);
    chk({tag, "_data"},    vid, 64'({wdata, act}), 64'd0);
    chk({tag, "_loaded"},  vid, loaded, 64'd0);
    chk({tag, "_cnt"},     vid, 64'({wr_cnt, mac_cnt, cam_cnt}), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    op_code = OP_NOP; addr = '0; data_bank = '0; data_in = '0;
    h0_v = 1'b0; h1_v = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---------------- vector tables ----------------
    nop_z = mk(OP_NOP, 9'h000, 16'h0, 16'h0, 1, 0,0,0,0,0,0, 16'h0000, 4'h0, 16'h0000, 16'h0000);
    nop_x = mk(OP_NOP, 9'h000, 16'h0, 16'h0, 0, 0,0,0,0,0,0, 16'h0000, 4'h0, 16'h0000, 16'h0000);

    //                 op      addr    db       din      chk wr mac cam st ls err bsel      rsel  wdata    act
    tbl_mac[0] = mk(OP_MAC, 9'h000, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 1, 0, 0, 16'h0001, 4'h1, 16'h0000, 16'hFFFF);
    tbl_mac[1] = mk(OP_MAC, 9'h005, 16'h0000, 16'hF0FF, 1, 0, 1, 0, 0, 1, 0, 16'h0001, 4'h1, 16'h0000, 16'hF0FF);
    tbl_mac[2] = mk(OP_MAC, 9'h008, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 1, 1, 0, 16'h0001, 4'h2, 16'h0000, 16'hFFFF);
    tbl_mac[3] = mk(OP_MAC, 9'h000, 16'h0010, 16'h1234, 1, 0, 1, 0, 1, 1, 0, 16'h0001, 4'h1, 16'h0010, 16'h1234);
    tbl_mac[4] = mk(OP_CAM, 9'h000, 16'h000F, 16'hAAAA, 1, 0, 0, 1, 0, 0, 0, 16'hFFFF, 4'h1, 16'h000F, 16'hAAAA);
    tbl_mac[5] = mk(OP_NOP, 9'h0A8, 16'h5555, 16'h5555, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 4'h1, 16'h000F, 16'hAAAA);
    tbl_mac[6] = mk(OP_NOP, 9'h000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 4'h1, 16'h000F, 16'hAAAA);

    tbl_err[0] = mk(OP_MAC, 9'h070, 16'h0101, 16'h0202, 1, 0, 1, 0, 1, 1, 1, 16'h0008, 4'h4, 16'h0101, 16'h0202);
    tbl_err[1] = mk(OP_WR,  9'h070, 16'h0303, 16'h0404, 1, 1, 0, 0, 0, 0, 0, 16'h0008, 4'h4, 16'h0303, 16'h0202);
    tbl_err[2] = mk(OP_MAC, 9'h070, 16'h0505, 16'h0606, 1, 0, 1, 0, 1, 1, 0, 16'h0008, 4'h4, 16'h0505, 16'h0606);
    tbl_err[3] = mk(OP_NOP, 9'h000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 16'h0008, 4'h4, 16'h0505, 16'h0606);

    // ---------------- reset hold and NOP stream ----------------
    rst_n = 1'b0;
    op_code = OP_NOP; addr = '0; data_bank = '0; data_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    repeat (4) step(nop_z);

    // ---------------- load every bank/row ----------------
    for (int i = 0; i < 64; i++) begin
      int b, r;
      b = i / 4;
      r = i % 4;
      step(mk(OP_WR, {4'(b), 2'(r), 3'b000}, 16'(b + r), 16'h0, 1,
              1, 0, 0, 0, 0, 0, 16'(1 << b), 4'(1 << r), 16'(b + r), 16'h0000));
      if (i == 2) begin
        chk("loaded_with_wr", vid, 64'(loaded[1:0]), 64'h1);
        chk("wr_cnt_first", vid, 64'(wr_cnt), 64'd1);
      end
    end

    // ---------------- MAC bursts and CAM on a full array ----------------
    for (int i = 0; i < 7; i++) step(tbl_mac[i]);
    step(nop_x);
    step(nop_x);
    chk("loaded_all", vid, loaded, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_cnt", vid, 64'(wr_cnt), 64'd64);
    chk("mac_cnt", vid, 64'(mac_cnt), 64'd4);
    chk("cam_cnt", vid, 64'(cam_cnt), 64'd1);
    chk("wr_cnt_sat_cw4", vid, 64'(s_wr_cnt), 64'd15);
    chk("mac_cnt_cw4", vid, 64'(s_mac_cnt), 64'd4);

    // ---------------- unloaded MAC, then write-then-MAC ----------------
    apply_reset();
    for (int i = 0; i < 4; i++) step(tbl_err[i]);
    step(nop_x);
    step(nop_x);
    chk("loaded_b3r2", vid, loaded, 64'h0000_0000_0000_4000);

    // ---------------- CAM with one bank missing the row ----------------
    for (int b = 0; b < 15; b++) begin
      step(mk(OP_WR, {4'(b), 2'd1, 3'b000}, 16'(b), 16'h0, 1,
              1, 0, 0, 0, 0, 0, 16'(1 << b), 4'h2, 16'(b), 16'h0606));
    end
    step(mk(OP_CAM, 9'h008, 16'h00AA, 16'h0055, 1, 0, 0, 1, 0, 0, 1, 16'hFFFF, 4'h2, 16'h00AA, 16'h0055));
    step(mk(OP_WR,  9'h1E8, 16'h000F, 16'h0000, 1, 1, 0, 0, 0, 0, 0, 16'h8000, 4'h2, 16'h000F, 16'h0055));
    step(mk(OP_CAM, 9'h00B, 16'h00BB, 16'h0066, 1, 0, 0, 1, 0, 0, 0, 16'hFFFF, 4'h2, 16'h00BB, 16'h0066));
    step(nop_x);
    step(nop_x);

    // ---------------- reset in the middle of a MAC burst ----------------
    step(mk(OP_MAC, 9'h008, 16'h0001, 16'h0002, 1, 0, 1, 0, 1, 0, 0, 16'h0001, 4'h2, 16'h0001, 16'h0002));
    step(mk(OP_MAC, 9'h008, 16'h0001, 16'h0002, 1, 0, 1, 0, 0, 0, 0, 16'h0001, 4'h2, 16'h0001, 16'h0002));
    step(mk(OP_MAC, 9'h008, 16'h0001, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000));
    step(mk(OP_MAC, 9'h008, 16'h0001, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 16'h0000, 16'h0000));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    h0_v = 1'b0;
    h1_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("no_last_in_reset", vid, 64'({mac_en, mac_last}), 64'd0);
    end
    op_code = OP_NOP;
    rst_n = 1'b1;
    repeat (4) step(nop_z);
    chk("loaded_after_reset", vid, loaded, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
